test_pe_issue_unq1: RTL and testbench
=====================================

Name: test_pe_issue_unq1

Overview:
- Initiator-side issue stage that drives operands and op_code into a combinational PE ALU (`test_pe_comp_unq1`-style port set) and collects `res`/`res_p`.
- Accepts an instruction stream over valid/ready and registers it into a single issue stage that drives the PE.
- Captures the PE result one cycle later and returns it through a credit-protected result FIFO with valid/ready.
- Sits between the tile config/stream logic and the PE datapath; adds registered timing and backpressure to an ALU that has none.

Parameters:
- DataWidth, 16, operand/result width; must match the attached PE.
- ResDepth, 4, result FIFO entries; legal range 3..16 (3 is the minimum for 1 op/cycle throughput).
- CntWidth, 16, width of the issued-op counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  issue stage can accept.
- in_op_code  in  9  PE op_code; [5:0] opcode, [6] is_signed.
- in_op_a  in  DataWidth  operand A.
- in_op_b  in  DataWidth  operand B.
- in_op_d_p  in  1  predicate/carry-in operand.
- pe_op_code  out  9  registered op_code to PE.
- pe_op_a  out  DataWidth  registered operand A to PE.
- pe_op_b  out  DataWidth  registered operand B to PE.
- pe_op_d_p  out  1  registered predicate to PE.
- pe_res  in  DataWidth  PE combinational result.
- pe_res_p  in  1  PE combinational predicate result.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- out_res  out  DataWidth  FIFO head result.
- out_res_p  out  1  FIFO head predicate.
- issue_cnt  out  CntWidth  count of ops issued to the PE since reset.

Behaviour:
- Reset: iss_v=0; pe_* outputs=0 (op_code 0 = ADD, harmless); FIFO empty; out_valid=0; out_res/out_res_p=0; issue_cnt=0.
- Reset asserted mid-operation discards the issue register and all FIFO contents the same edge. No partial result survives.
- Accept: the handshake fires when in_valid && in_ready. At that edge the pe_* registers load the in_* fields and iss_v<=1; otherwise iss_v<=0 and the pe_* registers hold their last value.
- The pe_* registers hold values while iss_v=0, so the PE inputs do not toggle.
- in_ready = (fifo_cnt + iss_v) < ResDepth. It is combinational from registers only, with no dependence on in_valid or out_ready.
- Capture: whenever iss_v=1, {pe_res, pe_res_p} is written into the FIFO tail at that edge. The credit rule guarantees the FIFO is never full at a push; an overflow is an assertion failure.
- issue_cnt increments on each capture and wraps modulo 2^CntWidth.
- Latency: accept at edge N → pe_* valid in cycle N..N+1 → FIFO write at edge N+1 → out_valid=1 in cycle after edge N+1. That is 2 cycles from accept to out_valid.
- Throughput: 1 op/cycle with out_ready held high.
- FIFO ordering: results leave in strict issue order.
- Simultaneous push and pop: fifo_cnt is unchanged, and a push into an empty FIFO with no pop makes the data visible the next cycle. There is no bypass.
- out_res/out_res_p reflect the head entry and are stable while out_valid && !out_ready.
- Full: with out_ready=0, exactly ResDepth ops are accepted before in_ready drops. in_ready reasserts the cycle after the first pop.
- Empty: out_valid=0; out_res holds the last popped value (don't-care to consumers).
- Pointers: rd/wr pointers wrap at ResDepth, including non-power-of-2 depths. fifo_cnt width is $clog2(ResDepth+1).
- Control states: IDLE (iss_v=0) and ISSUE (iss_v=1), encoded by iss_v alone.
  - IDLE→ISSUE on accept.
  - ISSUE→ISSUE on back-to-back accept.
  - ISSUE→IDLE when no accept occurs.

Decomposition:
- Shared package `test_pe_pkg`: PE opcode localparams (ADD 6'h0, SUB 6'h1, ABS 6'h3, GTE_MAX 6'h4, LTE_MIN 6'h5, EQ 6'h6, SEL 6'h8, MULT_0..2 6'hB..6'hD, RELU 6'hE, RSHFT 6'hF, LSHFT 6'h11, OR 6'h12, AND 6'h13, XOR 6'h14), the op_code bit-field positions, and a packed `pe_result_t` {res_p, res}.
- Sub-module `test_sync_fifo_unq1` (parameters Width, Depth; push/pop/full/empty/count) for the result FIFO; the top level holds the issue register, credit logic and counter.

Test Plan:
- Single op: ADD (op 9'h000), a=3, b=5, d_p=1, out_ready=1, with PE attached → out_valid exactly 2 cycles after accept, out_res=9, out_res_p=0, issue_cnt=1.
- Streaming: 8 back-to-back ops (SUB a=10 b=4; XOR a=16'hF0F0 b=16'hFF00; ...) with out_ready=1 → in_ready stays 1, results in order at 1/cycle, SUB gives 6, XOR gives 16'h0FF0.
- Backpressure: out_ready=0, in_valid held high → exactly 4 accepted, then in_ready=0. Raise out_ready for 1 cycle → one result popped, in_ready=1 the next cycle, no loss or duplication.
- Simultaneous push/pop at fifo_cnt=ResDepth-1 → count unchanged, ordering preserved, no overflow assertion.
- Reset mid-stream: 3 ops in flight (1 in issue, 2 in FIFO), reset for 1 cycle → out_valid=0, issue_cnt=0, pe_* outputs=0, in_ready=1 the following cycle.
- Counter wrap: CntWidth=4, issue 17 ops → issue_cnt=1.

Source files
------------

// File: rtl/test_pe_pkg.sv
// Shared definitions for the PE issue slice.
// Holds the opcode map, the op_code field layout and the packed PE result type.
package test_pe_pkg;

  localparam int unsigned OpCodeWidth = 9;
  localparam int unsigned OpcodeLsb   = 0;
  localparam int unsigned OpcodeMsb   = 5;
  localparam int unsigned SignedBit   = 6;
  localparam int unsigned PeDataWidth = 16;

  localparam logic [5:0] OpAdd    = 6'h00;
  localparam logic [5:0] OpSub    = 6'h01;
  localparam logic [5:0] OpAbs    = 6'h03;
  localparam logic [5:0] OpGteMax = 6'h04;
  localparam logic [5:0] OpLteMin = 6'h05;
  localparam logic [5:0] OpEq     = 6'h06;
  localparam logic [5:0] OpSel    = 6'h08;
  localparam logic [5:0] OpMult0  = 6'h0B;
  localparam logic [5:0] OpMult1  = 6'h0C;
  localparam logic [5:0] OpMult2  = 6'h0D;
  localparam logic [5:0] OpRelu   = 6'h0E;
  localparam logic [5:0] OpRshft  = 6'h0F;
  localparam logic [5:0] OpLshft  = 6'h11;
  localparam logic [5:0] OpOr     = 6'h12;
  localparam logic [5:0] OpAnd    = 6'h13;
  localparam logic [5:0] OpXor    = 6'h14;

  typedef struct packed {
    logic                   res_p;
    logic [PeDataWidth-1:0] res;
  } pe_result_t;

  // The issue stage state is iss_v itself.
  typedef enum logic {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } issue_state_e;

endpackage

// File: rtl/test_sync_fifo_unq1.sv
// Synchronous FIFO with wrap-at-Depth pointers (any Depth >= 2) and occupancy count.
// When empty the read port holds the most recently popped entry.
module test_sync_fifo_unq1 #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] last_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

  // Upstream credit accounting must never let a push meet a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/test_pe_issue_unq1.sv
// Issue stage in front of a combinational PE: registers one op, captures the PE result
// a cycle later into a credit-protected result FIFO.
module test_pe_issue_unq1
  import test_pe_pkg::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned ResDepth  = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OpCodeWidth-1:0] in_op_code,
  input  logic [DataWidth-1:0]   in_op_a,
  input  logic [DataWidth-1:0]   in_op_b,
  input  logic                   in_op_d_p,
  output logic [OpCodeWidth-1:0] pe_op_code,
  output logic [DataWidth-1:0]   pe_op_a,
  output logic [DataWidth-1:0]   pe_op_b,
  output logic                   pe_op_d_p,
  input  logic [DataWidth-1:0]   pe_res,
  input  logic                   pe_res_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DataWidth-1:0]   out_res,
  output logic                   out_res_p,
  output logic [CntWidth-1:0]    issue_cnt
);

  localparam int unsigned FifoCntW = $clog2(ResDepth + 1);

  issue_state_e             state_q, state_d;
  logic [OpCodeWidth-1:0]   op_code_q;
  logic [DataWidth-1:0]     op_a_q, op_b_q;
  logic                     op_d_p_q;
  logic [CntWidth-1:0]      issue_cnt_q;
  logic                     iss_v, accept;
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [FifoCntW-1:0]      fifo_cnt;
  logic [FifoCntW:0]        credits_used;

  assign iss_v = (state_q == StIssue);

  // The op sitting in the issue register already owns a FIFO slot.
  assign credits_used = {1'b0, fifo_cnt} + {{FifoCntW{1'b0}}, iss_v};
  assign in_ready     = !fifo_full && (credits_used < (FifoCntW+1)'(ResDepth));
  assign accept       = in_valid && in_ready;

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = accept ? StIssue : StIdle;
      StIssue: state_d = accept ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_code_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_d_p_q    <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands hold while idle so the PE inputs stay quiet.
      if (accept) begin
        op_code_q <= in_op_code;
        op_a_q    <= in_op_a;
        op_b_q    <= in_op_b;
        op_d_p_q  <= in_op_d_p;
      end
      if (iss_v) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  assign pe_op_code = op_code_q;
  assign pe_op_a    = op_a_q;
  assign pe_op_b    = op_b_q;
  assign pe_op_d_p  = op_d_p_q;
  assign issue_cnt  = issue_cnt_q;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;

  test_sync_fifo_unq1 #(
    .Width (DataWidth + 1),
    .Depth (ResDepth)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (iss_v),
    .wdata ({pe_res_p, pe_res}),
    .pop   (fifo_pop),
    .rdata ({out_res_p, out_res}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_test_pe_issue_unq1.sv
// Bench for test_pe_issue_unq1: stand-in PE, queue-based reference of in-flight results.
// A second instance with a 4-bit counter runs in lockstep to cover counter wrap.
module tb_test_pe_issue_unq1;
  import test_pe_pkg::*;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, in_op_d_p = 1'b0;
  logic [8:0]  in_op_code = '0;
  logic [15:0] in_op_a = '0, in_op_b = '0;

  logic        in_ready, out_valid, out_res_p, pe_op_d_p, pe_res_p;
  logic [8:0]  pe_op_code;
  logic [15:0] pe_op_a, pe_op_b, pe_res, out_res, issue_cnt;

  logic        in_ready_w, out_valid_w, out_res_p_w, pe_op_d_p_w, pe_res_p_w;
  logic [8:0]  pe_op_code_w;
  logic [15:0] pe_op_a_w, pe_op_b_w, pe_res_w, out_res_w;
  logic [3:0]  issue_cnt_w;

  always #5 clk = ~clk;

  // Stand-in PE: ADD uses carry-in and reports carry-out, SUB reports a>=b.
  function automatic pe_result_t pe_alu(input logic [8:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic dp);
    pe_result_t  r;
    logic [16:0] s;
    r = '0;
    case (op[5:0])
      OpAdd: begin
        s = {1'b0, a} + {1'b0, b} + {16'b0, dp};
        r.res = s[15:0];
        r.res_p = s[16];
      end
      OpSub: begin r.res = a - b; r.res_p = (a >= b); end
      OpXor: r.res = a ^ b;
      OpAnd: r.res = a & b;
      OpOr:  r.res = a | b;
      default: begin r.res = a + b; r.res_p = ^op; end
    endcase
    return r;
  endfunction

  assign {pe_res_p, pe_res}     = pe_alu(pe_op_code, pe_op_a, pe_op_b, pe_op_d_p);
  assign {pe_res_p_w, pe_res_w} = pe_alu(pe_op_code_w, pe_op_a_w, pe_op_b_w, pe_op_d_p_w);

  test_pe_issue_unq1 #(.DataWidth(16), .ResDepth(Depth), .CntWidth(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_d_p(in_op_d_p),
    .pe_op_code(pe_op_code), .pe_op_a(pe_op_a), .pe_op_b(pe_op_b), .pe_op_d_p(pe_op_d_p),
    .pe_res(pe_res), .pe_res_p(pe_res_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_res_p(out_res_p), .issue_cnt(issue_cnt)
  );

  test_pe_issue_unq1 #(.DataWidth(16), .ResDepth(Depth), .CntWidth(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_op_code(in_op_code), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_d_p(in_op_d_p),
    .pe_op_code(pe_op_code_w), .pe_op_a(pe_op_a_w), .pe_op_b(pe_op_b_w),
    .pe_op_d_p(pe_op_d_p_w), .pe_res(pe_res_w), .pe_res_p(pe_res_p_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_res(out_res_w),
    .out_res_p(out_res_p_w), .issue_cnt(issue_cnt_w)
  );

  typedef struct {
    pe_result_t r;
    int         acc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0, n_fail = 0;
  int          edge_n = 0, cnt_m = 0;
  logic        iss_m = 1'b0;
  logic [8:0]  last_op = '0;
  logic [15:0] last_a = '0, last_b = '0;
  logic        last_dp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rand_op();
    logic [5:0] lo;
    case ($urandom_range(0, 5))
      0: lo = OpAdd;
      1: lo = OpSub;
      2: lo = OpXor;
      3: lo = OpAnd;
      4: lo = OpOr;
      default: lo = OpRelu;
    endcase
    return {3'($urandom), lo};
  endfunction

  // One clock: drive inputs, check outputs at negedge against the model, advance the model.
  task automatic cycle(input logic v, input logic [8:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic dp, input logic ordy);
    logic acc, pop, exp_valid, exp_ready;
    exp_t e;
    in_valid = v; in_op_code = op; in_op_a = a; in_op_b = b; in_op_d_p = dp;
    out_ready = ordy;
    @(negedge clk);
    exp_ready = (q.size() < Depth);
    exp_valid = (q.size() > 0) && (q[0].acc < edge_n);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("in_ready_w", 32'(in_ready_w), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_valid_w", 32'(out_valid_w), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_res", 32'(out_res), 32'(q[0].r.res));
      chk("out_res_p", 32'(out_res_p), 32'(q[0].r.res_p));
      chk("out_res_w", 32'(out_res_w), 32'(q[0].r.res));
    end
    chk("issue_cnt", 32'(issue_cnt), 32'(cnt_m % 65536));
    chk("issue_cnt_w", 32'(issue_cnt_w), 32'(cnt_m % 16));
    chk("pe_op_a", 32'(pe_op_a), 32'(last_a));
    chk("pe_op_b", 32'(pe_op_b), 32'(last_b));
    chk("pe_op_code_dp", 32'({pe_op_code, pe_op_d_p}), 32'({last_op, last_dp}));
    acc = v && exp_ready;
    pop = exp_valid && ordy;
    @(posedge clk);
    edge_n++;
    if (iss_m) cnt_m++;
    iss_m = acc;
    if (pop) q.delete(0);
    if (acc) begin
      e.r = pe_alu(op, a, b, dp);
      e.acc = edge_n;
      q.push_back(e);
      last_op = op; last_a = a; last_b = b; last_dp = dp;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'h0, 16'h0, 16'h0, 1'b0, ordy);
  endtask

  task automatic rnd(input int n, input logic ordy);
    for (int i = 0; i < n; i++)
      cycle(1'b1, rand_op(), 16'($urandom), 16'($urandom), 1'($urandom), ordy);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    edge_n++;
    q.delete(); cnt_m = 0; iss_m = 1'b0;
    last_op = '0; last_a = '0; last_b = '0; last_dp = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_pe_op_code", 32'(pe_op_code), 32'd0);
    chk("rst_pe_op_a", 32'(pe_op_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_res", 32'({out_res_p, out_res}), 32'd0);
  endtask

  logic [8:0]  s_op [8] = '{9'h001, 9'h014, 9'h000, 9'h013, 9'h012, 9'h041, 9'h000, 9'h014};
  logic [15:0] s_a  [8] = '{16'd10, 16'hF0F0, 16'hFFFF, 16'h1234, 16'h00F0, 16'd3, 16'd7, 16'h5555};
  logic [15:0] s_b  [8] = '{16'd4, 16'hFF00, 16'd1, 16'h0FF0, 16'h0F00, 16'd9, 16'd8, 16'hAAAA};

  initial begin
    do_reset();

    // Single ADD with carry-in: 3+5+1 = 9, no carry out; visible two cycles after accept.
    cycle(1'b1, 9'h000, 16'd3, 16'd5, 1'b1, 1'b1);
    chk("single_not_yet", 32'(out_valid), 32'd0);
    cycle(1'b0, 9'h000, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("single_res", 32'({out_res_p, out_res}), 32'd9);
    idle(2, 1'b1);
    chk("single_cnt", 32'(issue_cnt), 32'd1);

    // Streaming back-to-back with sink always ready.
    for (int i = 0; i < 8; i++) cycle(1'b1, s_op[i], s_a[i], s_b[i], 1'b0, 1'b1);
    idle(4, 1'b1);

    // Backpressure: exactly Depth accepted, then a single pop frees one credit.
    rnd(6, 1'b0);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    rnd(1, 1'b1);
    rnd(3, 1'b0);
    idle(6, 1'b1);

    // Push and pop on the same edge with Depth-1 entries held.
    rnd(4, 1'b0);
    rnd(6, 1'b1);
    idle(5, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), rand_op(), 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    idle(6, 1'b1);

    // Reset with one op in issue and two in the FIFO.
    rnd(3, 1'b0);
    do_reset();
    idle(3, 1'b1);

    // Counter wrap on the 4-bit instance.
    rnd(17, 1'b1);
    idle(3, 1'b1);
    chk("wrap_cnt_w", 32'(issue_cnt_w), 32'd1);
    chk("wrap_cnt", 32'(issue_cnt), 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
